stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
Memory-access stage of the CPU pipeline. Consumes the execute stage's registered outputs: pc, ir, ma_addr/mode/size/data, wb_src/data/valid.
- Issues loads and stores on a req/ack data bus.
- Aligns and sign-extends load data, generates store byte masks.
- Stalls upstream while a bus transaction is outstanding, then registers results for write-back.
- Provides async forwarding outputs for the hazard unit.

Parameters:
- ACK_TIMEOUT, 16, max cycles waiting for dbus_ack_i before aborting with bus error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- pc_i  in  32  program counter
- ir_i  in  32  instruction register
- ma_addr_i  in  32  memory access address
- ma_mode_i  in  ma_mode_t  MA_X / MA_LOAD / MA_STORE
- ma_size_i  in  ma_size_t  B / H / W / BU / HU
- ma_data_i  in  32  store data
- wb_src_i  in  wb_src_t  write-back source
- wb_data_i  in  32  write-back data (non-load)
- wb_valid_i  in  1  write-back valid
- dbus_req_o  out  1  bus request
- dbus_we_o  out  1  write enable
- dbus_addr_o  out  30  word address (ma_addr[31:2])
- dbus_wmask_o  out  4  byte write mask
- dbus_wdata_o  out  32  lane-replicated write data
- dbus_ack_i  in  1  transaction complete
- dbus_rdata_i  in  32  read word, valid with ack
- stall_o  out  1  upstream must hold its outputs
- bus_err_o  out  1  one-cycle pulse on timeout
- wb_addr_async_o  out  5  ir_i[11:7]
- wb_data_async_o  out  32  forwarding data
- wb_ready_async_o  out  1  forwarding data usable this cycle
- wb_valid_async_o  out  1  = wb_valid_i
- empty_async_o  out  1  pc_i == NOP_PC
- pc_o, ir_o  out  32  to write-back stage
- wb_data_o  out  32  write-back data
- wb_valid_o  out  1  write-back valid

Behaviour:
- Reset values (async, any state):
  - pc_o=NOP_PC, ir_o=NOP_IR, wb_data_o=0, wb_valid_o=NOP_WB_VALID.
  - dbus_req_o=0, stall_o=0, bus_err_o=0, state IDLE, timeout counter 0.
- Memory op: ma_mode_i != MA_X and pc_i != NOP_PC. Otherwise the instruction passes through in 1 cycle: pc/ir/wb_data/wb_valid registered.
- FSM states:
  - IDLE: on a memory op, dbus_req_o=1 combinationally with addr/we/mask/wdata.
    - If dbus_ack_i in the same cycle: complete (zero-wait).
    - Else go to WAIT with stall_o=1.
  - WAIT: req and bus fields held (inputs held by stall); stall_o=1; counter increments.
    - On ack: complete, go to IDLE, stall_o=0 that cycle.
- Completion registers pc/ir/wb_valid_i. wb_data_o = extracted load data for loads, wb_data_i for stores.
- While stalled, the output register loads a bubble: pc_o=NOP_PC, ir_o=NOP_IR, wb_valid_o=0.
- Load extraction:
  - B/BU: lane addr[1:0], sign- or zero-extended.
  - H/HU: halfword addr[1], extended.
  - W: whole word.
- Store signals:
  - Mask: B = 0001<<addr[1:0]; H = 0011<<(2*addr[1]); W = 1111.
  - wdata: byte replicated ×4, half ×2.
  - dbus_we_o=1 only for MA_STORE.
- Timeout (ACK_TIMEOUT>0):
  - When the WAIT count reaches ACK_TIMEOUT without ack: pulse bus_err_o, drop req, return to IDLE.
  - The instruction retires with wb_valid_o=0.
  - Ack in the same cycle as timeout: ack wins, no error.
- dbus_ack_i in IDLE with no request is ignored.
- Forwarding: wb_ready_async_o = (ma_mode_i != MA_LOAD) or a load completing this cycle. wb_data_async_o = extracted load data in that case, else wb_data_i.
- Reset mid-WAIT: req drops immediately, any later ack is ignored.

Optional Feature:
- Macro: MA_MISALIGN_TRAP_EN.
- Defined: an H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, issues no bus request and does not stall. It pulses bus_err_o and retires with wb_valid_o=0.
- Undefined: misaligned low address bits are ignored (access forced to natural alignment); bus_err_o only on timeout.

Test Plan:
- LB from addr 0x103, rdata 0x80FF_FF7F, ack after 3 cycles -> stall_o high 3 cycles, bubbles out, then wb_data_o=0xFFFF_FF80, wb_valid_o=1.
- SH addr 0x202, data 0x0000_BEEF, zero-wait ack -> same cycle dbus_we_o=1, wmask=1100, wdata=0xBEEF_BEEF, dbus_addr_o=0x80, no stall.
- Non-memory op with wb_data_i=0x1234, wb_valid_i=1 -> next cycle wb_data_o=0x1234, no dbus_req_o.
- Load with no ack, ACK_TIMEOUT=16 -> after 16 WAIT cycles bus_err_o pulses 1 cycle, req drops, wb_valid_o=0; a late ack is ignored.
- rst_ni low during WAIT -> req/stall drop immediately, outputs at NOP values.
- LW addr 0x6: with MA_MISALIGN_TRAP_EN, no req and bus_err_o pulse; without, access to word address 0x1 returns the full word.

Source files
------------

// File: rtl/stage_memory.sv
// Memory-access pipeline stage: drives the req/ack data bus, aligns load data, stalls while a transfer is pending.
// Optional build macro MA_MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into bus errors instead of forced alignment.
module stage_memory #(
    parameter int          ACK_TIMEOUT  = 16,
    parameter logic [31:0] NOP_PC       = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_IR       = 32'h0000_0013,
    parameter logic        NOP_WB_VALID = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] ma_addr_i,
    input  logic [1:0]  ma_mode_i,
    input  logic [2:0]  ma_size_i,
    input  logic [31:0] ma_data_i,
    input  logic [1:0]  wb_src_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_valid_i,
    output logic        dbus_req_o,
    output logic        dbus_we_o,
    output logic [29:0] dbus_addr_o,
    output logic [3:0]  dbus_wmask_o,
    output logic [31:0] dbus_wdata_o,
    input  logic        dbus_ack_i,
    input  logic [31:0] dbus_rdata_i,
    output logic        stall_o,
    output logic        bus_err_o,
    output logic [4:0]  wb_addr_async_o,
    output logic [31:0] wb_data_async_o,
    output logic        wb_ready_async_o,
    output logic        wb_valid_async_o,
    output logic        empty_async_o,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] wb_data_o,
    output logic        wb_valid_o
);
    localparam logic [1:0] MA_X     = 2'd0;
    localparam logic [1:0] MA_LOAD  = 2'd1;
    localparam logic [1:0] MA_STORE = 2'd2;

    // ma_size_i[1:0]: 0 byte, 1 half, 2 word; ma_size_i[2] selects zero-extension (BU/HU)
    localparam int CW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int TO_M1 = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_bus_err;
    logic [31:0]   r_pc, r_ir, r_wb_data;
    logic          r_wb_valid;

    logic        w_memop, w_is_store, w_trap, w_bus_op;
    logic        w_req, w_done, w_stall, w_timeout, w_ld_done;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_data;
    logic        w_unused;

    assign w_unused   = ^wb_src_i;
    assign w_memop    = (ma_mode_i != MA_X) && (pc_i != NOP_PC);
    assign w_is_store = (ma_mode_i == MA_STORE);

`ifdef MA_MISALIGN_TRAP_EN
    logic w_misal;
    always_comb begin
        w_misal = 1'b0;
        case (ma_size_i[1:0])
            2'd0:    w_misal = 1'b0;
            2'd1:    w_misal = ma_addr_i[0];
            default: w_misal = (ma_addr_i[1:0] != 2'd0);
        endcase
    end
    assign w_trap = w_memop && w_misal;
`else
    assign w_trap = 1'b0;
`endif

    assign w_bus_op  = w_memop && !w_trap;
    assign w_timeout = (ACK_TIMEOUT > 0) && (r_state == S_WAIT) && !dbus_ack_i
                       && (r_cnt == CW'(TO_M1));

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == S_WAIT && w_state_nxt == S_WAIT) ? r_cnt + 1'b1 : '0;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_bus_op && !dbus_ack_i) w_state_nxt = S_WAIT;
            S_WAIT:  if (dbus_ack_i || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic; the timeout cycle retires the instruction, so it does not stall
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            S_IDLE:  w_req = w_bus_op;
            S_WAIT:  w_req = 1'b1;
            default: w_req = 1'b0;
        endcase
        w_done  = w_req && dbus_ack_i;
        w_stall = w_req && !dbus_ack_i && !w_timeout;
    end

    always_comb begin
        w_byte = dbus_rdata_i[7:0];
        case (ma_addr_i[1:0])
            2'd0: w_byte = dbus_rdata_i[7:0];
            2'd1: w_byte = dbus_rdata_i[15:8];
            2'd2: w_byte = dbus_rdata_i[23:16];
            2'd3: w_byte = dbus_rdata_i[31:24];
        endcase
        w_half = ma_addr_i[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
        case (ma_size_i[1:0])
            2'd0:    w_ld_data = {{24{~ma_size_i[2] & w_byte[7]}}, w_byte};
            2'd1:    w_ld_data = {{16{~ma_size_i[2] & w_half[15]}}, w_half};
            default: w_ld_data = dbus_rdata_i;
        endcase
    end

    always_comb begin
        case (ma_size_i[1:0])
            2'd0: begin
                dbus_wmask_o = 4'b0001 << ma_addr_i[1:0];
                dbus_wdata_o = {4{ma_data_i[7:0]}};
            end
            2'd1: begin
                dbus_wmask_o = ma_addr_i[1] ? 4'b1100 : 4'b0011;
                dbus_wdata_o = {2{ma_data_i[15:0]}};
            end
            default: begin
                dbus_wmask_o = 4'b1111;
                dbus_wdata_o = ma_data_i;
            end
        endcase
    end

    // Reset gates req/stall combinationally so they drop without waiting for a clock
    assign dbus_req_o  = w_req && rst_ni;
    assign stall_o     = w_stall && rst_ni;
    assign dbus_we_o   = w_is_store;
    assign dbus_addr_o = ma_addr_i[31:2];

    assign w_ld_done        = w_done && (ma_mode_i == MA_LOAD);
    assign wb_ready_async_o = (ma_mode_i != MA_LOAD) || w_ld_done;
    assign wb_data_async_o  = w_ld_done ? w_ld_data : wb_data_i;
    assign wb_addr_async_o  = ir_i[11:7];
    assign wb_valid_async_o = wb_valid_i;
    assign empty_async_o    = (pc_i == NOP_PC);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc       <= NOP_PC;
            r_ir       <= NOP_IR;
            r_wb_data  <= '0;
            r_wb_valid <= NOP_WB_VALID;
            r_bus_err  <= 1'b0;
        end else begin
            r_bus_err <= w_timeout || w_trap;
            if (w_stall) begin
                r_pc       <= NOP_PC;
                r_ir       <= NOP_IR;
                r_wb_valid <= 1'b0;
            end else begin
                r_pc       <= pc_i;
                r_ir       <= ir_i;
                r_wb_data  <= (w_done && !w_is_store) ? w_ld_data : wb_data_i;
                r_wb_valid <= wb_valid_i && !w_timeout && !w_trap;
            end
        end
    end

    assign pc_o       = r_pc;
    assign ir_o       = r_ir;
    assign wb_data_o  = r_wb_data;
    assign wb_valid_o = r_wb_valid;
    assign bus_err_o  = r_bus_err;
endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: pass-through, loads/stores, wait states, timeout, reset mid-wait, misalignment.
module tb_stage_memory;
    localparam logic [31:0] NOP_PC = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_IR = 32'h0000_0013;
    localparam logic [1:0]  MA_X = 2'd0, MA_LOAD = 2'd1, MA_STORE = 2'd2;
    localparam logic [2:0]  SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BU = 3'd4, SZ_HU = 3'd5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] pc_i = NOP_PC, ir_i = NOP_IR, ma_addr_i = '0, ma_data_i = '0;
    logic [1:0]  ma_mode_i = MA_X, wb_src_i = '0;
    logic [2:0]  ma_size_i = SZ_W;
    logic [31:0] wb_data_i = '0, dbus_rdata_i = '0;
    logic        wb_valid_i = 1'b0, dbus_ack_i = 1'b0;
    logic        dbus_req_o, dbus_we_o, stall_o, bus_err_o;
    logic [29:0] dbus_addr_o;
    logic [3:0]  dbus_wmask_o;
    logic [31:0] dbus_wdata_o, wb_data_async_o, pc_o, ir_o, wb_data_o;
    logic [4:0]  wb_addr_async_o;
    logic        wb_ready_async_o, wb_valid_async_o, empty_async_o, wb_valid_o;

    int total = 0;
    int bad   = 0;

    stage_memory #(.ACK_TIMEOUT(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pc_i(pc_i), .ir_i(ir_i), .ma_addr_i(ma_addr_i),
        .ma_mode_i(ma_mode_i), .ma_size_i(ma_size_i), .ma_data_i(ma_data_i),
        .wb_src_i(wb_src_i), .wb_data_i(wb_data_i), .wb_valid_i(wb_valid_i),
        .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wmask_o(dbus_wmask_o), .dbus_wdata_o(dbus_wdata_o), .dbus_ack_i(dbus_ack_i),
        .dbus_rdata_i(dbus_rdata_i), .stall_o(stall_o), .bus_err_o(bus_err_o),
        .wb_addr_async_o(wb_addr_async_o), .wb_data_async_o(wb_data_async_o),
        .wb_ready_async_o(wb_ready_async_o), .wb_valid_async_o(wb_valid_async_o),
        .empty_async_o(empty_async_o), .pc_o(pc_o), .ir_o(ir_o),
        .wb_data_o(wb_data_o), .wb_valid_o(wb_valid_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pc_i = NOP_PC; ir_i = NOP_IR; ma_mode_i = MA_X; dbus_ack_i = 1'b0;
        wb_valid_i = 1'b0; wb_data_i = '0;
    endtask

    task automatic mem(input logic [31:0] pc, input logic [1:0] mode, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] data, input logic ack);
        pc_i = pc; ir_i = 32'h0000_0A83; ma_mode_i = mode; ma_size_i = size;
        ma_addr_i = addr; ma_data_i = data; dbus_ack_i = ack;
    endtask

    initial begin
        int nstall;
        // Reset state
        tick; tick;
        chk("rst_pc", pc_o, NOP_PC);
        chk("rst_ir", ir_o, NOP_IR);
        chk("rst_wbd", wb_data_o, 32'h0);
        chk("rst_wbv", {31'b0, wb_valid_o}, 32'h0);
        chk("rst_req", {31'b0, dbus_req_o}, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'h0);
        chk("rst_err", {31'b0, bus_err_o}, 32'h0);
        chk("idle_empty", {31'b0, empty_async_o}, 32'h1);
        rst_n = 1'b1;
        tick;

        // Non-memory pass-through
        pc_i = 32'h100; ir_i = 32'h0000_0A93; ma_mode_i = MA_X;
        wb_data_i = 32'h1234; wb_valid_i = 1'b1;
        #1;
        chk("alu_req", {31'b0, dbus_req_o}, 32'h0);
        chk("alu_ready", {31'b0, wb_ready_async_o}, 32'h1);
        chk("alu_fwd", wb_data_async_o, 32'h1234);
        chk("alu_waddr", {27'b0, wb_addr_async_o}, 32'd21);
        chk("alu_empty", {31'b0, empty_async_o}, 32'h0);
        tick;
        chk("alu_pc", pc_o, 32'h100);
        chk("alu_wbd", wb_data_o, 32'h1234);
        chk("alu_wbv", {31'b0, wb_valid_o}, 32'h1);

        // SH zero-wait
        mem(32'h104, MA_STORE, SZ_H, 32'h202, 32'h0000_BEEF, 1'b1);
        wb_data_i = 32'h55; wb_valid_i = 1'b0;
        #1;
        chk("sh_req", {31'b0, dbus_req_o}, 32'h1);
        chk("sh_we", {31'b0, dbus_we_o}, 32'h1);
        chk("sh_mask", {28'b0, dbus_wmask_o}, 32'hC);
        chk("sh_wdata", dbus_wdata_o, 32'hBEEF_BEEF);
        chk("sh_addr", {2'b0, dbus_addr_o}, 32'h80);
        chk("sh_stall", {31'b0, stall_o}, 32'h0);
        tick;
        chk("sh_pc", pc_o, 32'h104);
        chk("sh_wbd", wb_data_o, 32'h55);

        // SB lane 1, SW
        mem(32'h108, MA_STORE, SZ_B, 32'h001, 32'h1234_56A5, 1'b1);
        #1;
        chk("sb_mask", {28'b0, dbus_wmask_o}, 32'h2);
        chk("sb_wdata", dbus_wdata_o, 32'hA5A5_A5A5);
        tick;
        mem(32'h10C, MA_STORE, SZ_W, 32'h300, 32'hCAFE_F00D, 1'b1);
        #1;
        chk("sw_mask", {28'b0, dbus_wmask_o}, 32'hF);
        chk("sw_wdata", dbus_wdata_o, 32'hCAFE_F00D);
        tick;

        // LB with 3 stall cycles
        mem(32'h110, MA_LOAD, SZ_B, 32'h103, 32'h0, 1'b0);
        wb_valid_i = 1'b1; wb_data_i = 32'h77;
        nstall = 0;
        #1;
        chk("lb_req", {31'b0, dbus_req_o}, 32'h1);
        chk("lb_we", {31'b0, dbus_we_o}, 32'h0);
        chk("lb_ready0", {31'b0, wb_ready_async_o}, 32'h0);
        if (stall_o) nstall++;
        for (int i = 0; i < 2; i++) begin
            tick;
            if (stall_o) nstall++;
            chk("lb_bubble_pc", pc_o, NOP_PC);
            chk("lb_bubble_v", {31'b0, wb_valid_o}, 32'h0);
            chk("lb_hold_req", {31'b0, dbus_req_o}, 32'h1);
        end
        tick;
        chk("lb_bubble_pc3", pc_o, NOP_PC);
        dbus_ack_i = 1'b1; dbus_rdata_i = 32'h80FF_FF7F;
        #1;
        chk("lb_ack_stall", {31'b0, stall_o}, 32'h0);
        chk("lb_ready", {31'b0, wb_ready_async_o}, 32'h1);
        chk("lb_fwd", wb_data_async_o, 32'hFFFF_FF80);
        chk("lb_nstall", nstall, 32'd3);
        tick;
        chk("lb_wbd", wb_data_o, 32'hFFFF_FF80);
        chk("lb_wbv", {31'b0, wb_valid_o}, 32'h1);
        chk("lb_pc", pc_o, 32'h110);

        // LHU / LH / LBU zero-wait
        mem(32'h114, MA_LOAD, SZ_HU, 32'h102, 32'h0, 1'b1);
        dbus_rdata_i = 32'h80FF_1234;
        tick;
        chk("lhu_wbd", wb_data_o, 32'h0000_80FF);
        mem(32'h118, MA_LOAD, SZ_H, 32'h102, 32'h0, 1'b1);
        tick;
        chk("lh_wbd", wb_data_o, 32'hFFFF_80FF);
        mem(32'h11C, MA_LOAD, SZ_BU, 32'h103, 32'h0, 1'b1);
        tick;
        chk("lbu_wbd", wb_data_o, 32'h0000_0080);
        idle;
        tick;

        // Timeout: 16 WAIT cycles then error
        mem(32'h120, MA_LOAD, SZ_W, 32'h400, 32'h0, 1'b0);
        wb_valid_i = 1'b1;
        nstall = 0;
        for (int i = 0; i < 16; i++) begin
            tick;
            if (stall_o) nstall++;
            if (bus_err_o) nstall += 100;
        end
        chk("to_nstall", nstall, 32'd15);
        chk("to_last_stall", {31'b0, stall_o}, 32'h0);
        chk("to_last_req", {31'b0, dbus_req_o}, 32'h1);
        tick;
        chk("to_err", {31'b0, bus_err_o}, 32'h1);
        chk("to_wbv", {31'b0, wb_valid_o}, 32'h0);
        chk("to_pc", pc_o, 32'h120);
        idle;
        dbus_ack_i = 1'b1;
        #1;
        chk("to_late_req", {31'b0, dbus_req_o}, 32'h0);
        tick;
        chk("to_err_pulse", {31'b0, bus_err_o}, 32'h0);
        chk("to_late_pc", pc_o, NOP_PC);
        dbus_ack_i = 1'b0;

        // Reset during WAIT
        mem(32'h124, MA_LOAD, SZ_W, 32'h500, 32'h0, 1'b0);
        tick; tick;
        chk("rw_stall", {31'b0, stall_o}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_req", {31'b0, dbus_req_o}, 32'h0);
        chk("rw_stall0", {31'b0, stall_o}, 32'h0);
        chk("rw_pc", pc_o, NOP_PC);
        chk("rw_ir", ir_o, NOP_IR);
        idle;
        dbus_ack_i = 1'b1;
        tick;
        rst_n = 1'b1;
        tick;
        chk("rw_after_req", {31'b0, dbus_req_o}, 32'h0);
        chk("rw_after_pc", pc_o, NOP_PC);
        chk("rw_after_err", {31'b0, bus_err_o}, 32'h0);
        dbus_ack_i = 1'b0;

        // LW misaligned at 0x6
        mem(32'h128, MA_LOAD, SZ_W, 32'h6, 32'h0, 1'b1);
        dbus_rdata_i = 32'hDEAD_BEEF; wb_valid_i = 1'b1;
        #1;
`ifdef MA_MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, dbus_req_o}, 32'h0);
        chk("mis_stall", {31'b0, stall_o}, 32'h0);
        tick;
        chk("mis_err", {31'b0, bus_err_o}, 32'h1);
        chk("mis_wbv", {31'b0, wb_valid_o}, 32'h0);
`else
        chk("mis_req", {31'b0, dbus_req_o}, 32'h1);
        chk("mis_addr", {2'b0, dbus_addr_o}, 32'h1);
        tick;
        chk("mis_wbd", wb_data_o, 32'hDEAD_BEEF);
        chk("mis_wbv", {31'b0, wb_valid_o}, 32'h1);
        chk("mis_err", {31'b0, bus_err_o}, 32'h0);
`endif
        idle;
        tick;
        chk("end_err", {31'b0, bus_err_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
